// File: rtl/dot_pkg.sv
// Shared constants, cell index type and round-state encoding for the dot-grid round sequencer.
// No ports; imported by pix_to_cell and dot_round_ctrl.
package dot_pkg;

  localparam int unsigned GRID_N     = 12;
  localparam int unsigned CELL_SHIFT = 5;
  localparam int unsigned PIX_W      = 10;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned DOTS_W     = 8;
  localparam int unsigned LEVEL_W    = 4;
  localparam int unsigned TOTAL_DOTS = GRID_N * GRID_N;

  typedef logic [IDX_W-1:0] cell_idx_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REFILL     = 3'd1,
    PLAY       = 3'd2,
    CLEAR      = 3'd3,
    LEVEL_DONE = 3'd4
  } round_state_t;

endpackage

// File: rtl/pix_to_cell.sv
// Maps a player pixel position onto the dot grid (combinational).
// Ports:
//   px, py     in   player pixel position
//   row_c      out  0-based grid row (don't-care when off-grid)
//   col_c      out  0-based grid column (don't-care when off-grid)
//   in_grid_c  out  1 when the position lies inside the GRID_N x GRID_N playfield
module pix_to_cell
  import dot_pkg::*;
(
  input  logic [PIX_W-1:0] px,
  input  logic [PIX_W-1:0] py,
  output cell_idx_t        row_c,
  output cell_idx_t        col_c,
  output logic             in_grid_c
);

  localparam int unsigned CW = PIX_W - CELL_SHIFT;

  logic [CW-1:0] cx;
  logic [CW-1:0] cy;
  logic          unused_lsb;

  assign cx = px[PIX_W-1:CELL_SHIFT];
  assign cy = py[PIX_W-1:CELL_SHIFT];

  // Sub-cell pixel bits do not affect which cell the player occupies.
  assign unused_lsb = ^{px[CELL_SHIFT-1:0], py[CELL_SHIFT-1:0]};

  // Cell 0 and cells beyond GRID_N form the border ring around the playfield.
  assign in_grid_c = (cx >= CW'(1)) && (cx <= CW'(GRID_N)) &&
                     (cy >= CW'(1)) && (cy <= CW'(GRID_N));

  assign col_c = IDX_W'(cx - CW'(1));
  assign row_c = IDX_W'(cy - CW'(1));

endmodule

// File: rtl/dot_round_ctrl.sv
// Round sequencer for the 12x12 dot grid: queries the dot store at the player's cell,
// issues clear requests over a valid/ready handshake, keeps score / dots left / level
// and steps through IDLE, REFILL, PLAY, CLEAR and LEVEL_DONE.
// Optional feature: define DOT_ROUND_PAUSE_EN to add the `pause` input (freezes clear
// issue in PLAY and the LEVEL_DONE hold counter; an open CLEAR still completes).
// Ports:
//   frame_clk, Reset     clock and synchronous active-high reset
//   start                begin a game from IDLE
//   pause                (DOT_ROUND_PAUSE_EN only) hold play
//   px, py               player pixel position
//   q_row, q_col         combinational dot-store query address
//   q_dot                dot-store answer for the query address
//   clr_valid/ready      clear handshake; clr_row/clr_col address of the clear
//   refill               1-cycle pulse: dot store refills every cell
//   score, dots_left, level, round_done, state_o   HUD / debug outputs
module dot_round_ctrl
  import dot_pkg::*;
#(
  parameter int unsigned DOT_POINTS  = 10,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned SCORE_W     = 16
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start,
`ifdef DOT_ROUND_PAUSE_EN
  input  logic               pause,
`endif
  input  logic [PIX_W-1:0]   px,
  input  logic [PIX_W-1:0]   py,
  output cell_idx_t          q_row,
  output cell_idx_t          q_col,
  input  logic               q_dot,
  output logic               clr_valid,
  input  logic               clr_ready,
  output cell_idx_t          clr_row,
  output cell_idx_t          clr_col,
  output logic               refill,
  output logic [SCORE_W-1:0] score,
  output logic [DOTS_W-1:0]  dots_left,
  output logic [LEVEL_W-1:0] level,
  output logic               round_done,
  output logic [2:0]         state_o
);

  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  round_state_t       state, state_n;
  logic               clr_valid_n, refill_n, round_done_n;
  cell_idx_t          clr_row_n, clr_col_n;
  logic [SCORE_W-1:0] score_n, score_sat;
  logic [SCORE_W:0]   score_sum;
  logic [DOTS_W-1:0]  dots_n;
  logic [LEVEL_W-1:0] level_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic               in_grid;
  logic               paused;

`ifdef DOT_ROUND_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // Query address follows the player directly; the dot store answers in the same cycle.
  pix_to_cell u_pix_to_cell (
    .px        (px),
    .py        (py),
    .row_c     (q_row),
    .col_c     (q_col),
    .in_grid_c (in_grid)
  );

  // Score add with saturation at all-ones.
  assign score_sum = {1'b0, score} + (SCORE_W+1)'(DOT_POINTS);
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    clr_valid_n  = clr_valid;
    clr_row_n    = clr_row;
    clr_col_n    = clr_col;
    refill_n     = 1'b0;
    round_done_n = 1'b0;
    score_n      = score;
    dots_n       = dots_left;
    level_n      = level;
    hold_n       = hold_cnt;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n  = REFILL;
          refill_n = 1'b1;
          dots_n   = DOTS_W'(TOTAL_DOTS);
        end
      end

      REFILL: state_n = PLAY;

      PLAY: begin
        if (dots_left == '0) begin
          state_n      = LEVEL_DONE;
          round_done_n = 1'b1;
          hold_n       = '0;
        end else if (!paused && in_grid && q_dot) begin
          state_n     = CLEAR;
          clr_valid_n = 1'b1;
          clr_row_n   = q_row;
          clr_col_n   = q_col;
        end
      end

      CLEAR: begin
        if (clr_ready) begin
          clr_valid_n = 1'b0;
          score_n     = score_sat;
          dots_n      = dots_left - DOTS_W'(1);
          if (dots_left == DOTS_W'(1)) begin
            state_n      = LEVEL_DONE;
            round_done_n = 1'b1;
            hold_n       = '0;
          end else begin
            state_n = PLAY;
          end
        end
      end

      LEVEL_DONE: begin
        if (!paused) begin
          if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
            state_n  = REFILL;
            refill_n = 1'b1;
            dots_n   = DOTS_W'(TOTAL_DOTS);
            hold_n   = '0;
            level_n  = (level == '1) ? level : level + LEVEL_W'(1);
          end else begin
            hold_n = hold_cnt + HOLD_W'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      clr_valid  <= 1'b0;
      clr_row    <= '0;
      clr_col    <= '0;
      refill     <= 1'b0;
      round_done <= 1'b0;
      score      <= '0;
      dots_left  <= '0;
      level      <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      clr_valid  <= clr_valid_n;
      clr_row    <= clr_row_n;
      clr_col    <= clr_col_n;
      refill     <= refill_n;
      round_done <= round_done_n;
      score      <= score_n;
      dots_left  <= dots_n;
      level      <= level_n;
      hold_cnt   <= hold_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_dot_round_ctrl.sv
// Self-checking bench for dot_round_ctrl; expectations come from a score/dots/level model
// built from the round rules (cell = pixel / 32, border cells dead, +10 per clear).
module tb_dot_round_ctrl;

  localparam int HOLD  = 60;
  localparam int PTS   = 10;
  localparam int SMAX  = 65535;
  localparam logic [2:0] S_IDLE = 3'd0, S_REFILL = 3'd1, S_PLAY = 3'd2,
                         S_CLEAR = 3'd3, S_LDONE = 3'd4;

  logic        frame_clk = 1'b0;
  logic        Reset, start, pause, q_dot, clr_ready;
  logic [9:0]  px, py;
  logic [3:0]  q_row, q_col, clr_row, clr_col, level;
  logic        clr_valid, refill, round_done;
  logic [15:0] score;
  logic [7:0]  dots_left;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;
  int m_score, m_dots, m_level;

  always #5 frame_clk = ~frame_clk;

  dot_round_ctrl dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .start      (start),
`ifdef DOT_ROUND_PAUSE_EN
    .pause      (pause),
`endif
    .px         (px),
    .py         (py),
    .q_row      (q_row),
    .q_col      (q_col),
    .q_dot      (q_dot),
    .clr_valid  (clr_valid),
    .clr_ready  (clr_ready),
    .clr_row    (clr_row),
    .clr_col    (clr_col),
    .refill     (refill),
    .score      (score),
    .dots_left  (dots_left),
    .level      (level),
    .round_done (round_done),
    .state_o    (state_o)
  );

  // refill and clr_valid must never overlap.
  always @(negedge frame_clk) begin
    total++;
    if (refill && clr_valid) begin
      bad++;
      $display("FAIL overlap: refill=%0b clr_valid=%0b required not both 1", refill, clr_valid);
    end
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; pause = 1'b0; q_dot = 1'b0; clr_ready = 1'b0;
    px = '0; py = '0;
    tick(); tick();
    m_score = 0; m_dots = 0; m_level = 0;
    total++; if (state_o !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_o, S_IDLE); end
    total++; if (score !== 16'd0) begin bad++; $display("FAIL reset_score: got %0d want 0", score); end
    total++; if (dots_left !== 8'd0) begin bad++; $display("FAIL reset_dots: got %0d want 0", dots_left); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if ({clr_valid, refill, round_done} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {clr_valid, refill, round_done}); end
    total++; if ({clr_row, clr_col} !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", {clr_row, clr_col}); end
    Reset = 1'b0;
    tick();
    total++; if (state_o !== S_IDLE) begin bad++; $display("FAIL idle_hold: got %0d want %0d", state_o, S_IDLE); end
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    m_dots = 144;
    total++; if (state_o !== S_REFILL) begin bad++; $display("FAIL start_state: got %0d want %0d", state_o, S_REFILL); end
    total++; if (refill !== 1'b1) begin bad++; $display("FAIL start_refill: got %0b want 1", refill); end
    total++; if (dots_left !== 8'(m_dots)) begin bad++; $display("FAIL start_dots: got %0d want %0d", dots_left, m_dots); end
    tick();
    total++; if (state_o !== S_PLAY) begin bad++; $display("FAIL play_state: got %0d want %0d", state_o, S_PLAY); end
    total++; if (refill !== 1'b0) begin bad++; $display("FAIL refill_pulse: got %0b want 0", refill); end
    tick();
    total++; if ({state_o, refill} !== {S_PLAY, 1'b0}) begin bad++; $display("FAIL start_ignored: got %0d/%0b want %0d/0", state_o, refill, S_PLAY); end
    start = 1'b0;
  endtask

  task automatic test_clear_handshake();
    px = 10'd64; py = 10'd32; q_dot = 1'b1; clr_ready = 1'b0;
    #1;
    total++; if ({q_row, q_col} !== {4'd0, 4'd1}) begin bad++; $display("FAIL query_addr: got %0d,%0d want 0,1", q_row, q_col); end
    tick();
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({state_o, clr_valid, clr_row, clr_col} !== {S_CLEAR, 1'b1, 4'd0, 4'd1}) begin
        bad++; $display("FAIL clear_hold%0d: got st=%0d v=%0b r=%0d c=%0d want st=3 v=1 r=0 c=1", c, state_o, clr_valid, clr_row, clr_col);
      end
      px = 10'(200 + c * 40); py = 10'(300 - c * 50);
      if (c == 2) clr_ready = 1'b1;
      tick();
    end
    clr_ready = 1'b0; q_dot = 1'b0;
    m_score += PTS; m_dots--;
    total++; if (clr_valid !== 1'b0) begin bad++; $display("FAIL hs_valid: got %0b want 0", clr_valid); end
    total++; if (score !== 16'(m_score)) begin bad++; $display("FAIL hs_score: got %0d want %0d", score, m_score); end
    total++; if (dots_left !== 8'(m_dots)) begin bad++; $display("FAIL hs_dots: got %0d want %0d", dots_left, m_dots); end
    total++; if (state_o !== S_PLAY) begin bad++; $display("FAIL hs_state: got %0d want %0d", state_o, S_PLAY); end
  endtask

  task automatic test_invalid_cells();
    int xs[6] = '{8, 416, 64, 64, 0, 1023};
    int ys[6] = '{64, 64, 8, 416, 0, 1023};
    q_dot = 1'b1;
    for (int i = 0; i < 6; i++) begin
      px = 10'(xs[i]); py = 10'(ys[i]);
      tick(); tick();
      total++;
      if ({clr_valid, state_o, score} !== {1'b0, S_PLAY, 16'(m_score)}) begin
        bad++; $display("FAIL offgrid(%0d,%0d): got v=%0b st=%0d sc=%0d want v=0 st=2 sc=%0d", xs[i], ys[i], clr_valid, state_o, score, m_score);
      end
    end
    q_dot = 1'b0;
  endtask

  task automatic test_random();
    int x, y, cx, cy, dly;
    logic d, hit;
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 479)); y = int'($urandom_range(0, 479));
      d = 1'($urandom_range(0, 1)); dly = int'($urandom_range(0, 3));
      if (i == 0) begin x = 32; y = 32; d = 1'b1; end
      if (i == 1) begin x = 415; y = 415; d = 1'b1; end
      cx = x / 32; cy = y / 32;
      hit = d && cx >= 1 && cx <= 12 && cy >= 1 && cy <= 12;
      px = 10'(x); py = 10'(y); q_dot = d; clr_ready = 1'b0;
      tick();
      if (hit) begin
        total++;
        if ({clr_valid, clr_row, clr_col} !== {1'b1, 4'(cy - 1), 4'(cx - 1)}) begin
          bad++; $display("FAIL rnd_issue%0d: got v=%0b r=%0d c=%0d want v=1 r=%0d c=%0d", i, clr_valid, clr_row, clr_col, cy - 1, cx - 1);
        end
        for (int k = 0; k < dly; k++) begin
          px = 10'($urandom_range(0, 1023)); py = 10'($urandom_range(0, 1023));
          q_dot = 1'($urandom_range(0, 1));
          tick();
          total++;
          if ({clr_valid, clr_row, clr_col} !== {1'b1, 4'(cy - 1), 4'(cx - 1)}) begin
            bad++; $display("FAIL rnd_hold%0d: got v=%0b r=%0d c=%0d want v=1 r=%0d c=%0d", i, clr_valid, clr_row, clr_col, cy - 1, cx - 1);
          end
        end
        clr_ready = 1'b1;
        tick();
        clr_ready = 1'b0; q_dot = 1'b0;
        m_score += PTS; m_dots--;
        total++;
        if ({clr_valid, state_o, score, dots_left} !== {1'b0, S_PLAY, 16'(m_score), 8'(m_dots)}) begin
          bad++; $display("FAIL rnd_done%0d: got v=%0b st=%0d sc=%0d dl=%0d want v=0 st=2 sc=%0d dl=%0d", i, clr_valid, state_o, score, dots_left, m_score, m_dots);
        end
      end else begin
        q_dot = 1'b0;
        total++;
        if ({clr_valid, state_o} !== {1'b0, S_PLAY}) begin
          bad++; $display("FAIL rnd_nohit%0d: got v=%0b st=%0d want v=0 st=2", i, clr_valid, state_o);
        end
      end
    end
  endtask

  // Clears every remaining dot, then walks LEVEL_DONE back into PLAY.
  task automatic run_level(input bit detail);
    int n;
    n = m_dots;
    px = 10'd64; py = 10'd32; q_dot = 1'b1; clr_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      if (detail || k == n - 1) begin
        total++;
        if ({state_o, clr_valid} !== {S_CLEAR, 1'b1}) begin
          bad++; $display("FAIL lvl_clear%0d: got st=%0d v=%0b want st=3 v=1", k, state_o, clr_valid);
        end
      end
      tick();
      m_score = (m_score + PTS > SMAX) ? SMAX : m_score + PTS;
      m_dots--;
    end
    q_dot = 1'b0; clr_ready = 1'b0;
    total++;
    if ({state_o, round_done, dots_left} !== {S_LDONE, 1'b1, 8'd0}) begin
      bad++; $display("FAIL lvl_entry: got st=%0d rd=%0b dl=%0d want st=4 rd=1 dl=0", state_o, round_done, dots_left);
    end
    total++; if (score !== 16'(m_score)) begin bad++; $display("FAIL lvl_score: got %0d want %0d", score, m_score); end
    repeat (HOLD - 1) tick();
    total++;
    if ({state_o, round_done, level} !== {S_LDONE, 1'b0, 4'(m_level)}) begin
      bad++; $display("FAIL lvl_hold: got st=%0d rd=%0b lv=%0d want st=4 rd=0 lv=%0d", state_o, round_done, level, m_level);
    end
    tick();
    m_level = (m_level == 15) ? 15 : m_level + 1;
    m_dots = 144;
    total++;
    if ({state_o, refill, level, dots_left} !== {S_REFILL, 1'b1, 4'(m_level), 8'(m_dots)}) begin
      bad++; $display("FAIL lvl_refill: got st=%0d rf=%0b lv=%0d dl=%0d want st=1 rf=1 lv=%0d dl=%0d", state_o, refill, level, dots_left, m_level, m_dots);
    end
    tick();
    total++;
    if ({state_o, refill} !== {S_PLAY, 1'b0}) begin
      bad++; $display("FAIL lvl_play: got st=%0d rf=%0b want st=2 rf=0", state_o, refill);
    end
  endtask

  task automatic test_level_done();
    run_level(1'b1);
  endtask

  task automatic test_saturation();
    for (int l = 0; l < 47; l++) run_level(1'b0);
    total++; if (score !== 16'hFFFF) begin bad++; $display("FAIL score_sat: got %0d want 65535", score); end
    total++; if (level !== 4'd15) begin bad++; $display("FAIL level_sat: got %0d want 15", level); end
  endtask

  task automatic test_reset_mid_clear();
    px = 10'd96; py = 10'd96; q_dot = 1'b1; clr_ready = 1'b0;
    tick();
    total++; if (clr_valid !== 1'b1) begin bad++; $display("FAIL rst_pre: got %0b want 1", clr_valid); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0; q_dot = 1'b0;
    m_score = 0; m_dots = 0; m_level = 0;
    total++;
    if ({state_o, clr_valid, score, level, dots_left} !== {S_IDLE, 1'b0, 16'd0, 4'd0, 8'd0}) begin
      bad++; $display("FAIL rst_mid: got st=%0d v=%0b sc=%0d lv=%0d dl=%0d want st=0 v=0 sc=0 lv=0 dl=0", state_o, clr_valid, score, level, dots_left);
    end
    tick();
    total++; if (state_o !== S_IDLE) begin bad++; $display("FAIL rst_idle: got %0d want 0", state_o); end
  endtask

`ifdef DOT_ROUND_PAUSE_EN
  task automatic test_pause();
    start = 1'b1; tick(); start = 1'b0; tick();
    m_dots = 144;
    pause = 1'b1; px = 10'd64; py = 10'd32; q_dot = 1'b1;
    repeat (3) begin
      tick();
      total++;
      if ({clr_valid, state_o} !== {1'b0, S_PLAY}) begin
        bad++; $display("FAIL pause_hold: got v=%0b st=%0d want v=0 st=2", clr_valid, state_o);
      end
    end
    pause = 1'b0;
    tick();
    total++; if ({clr_valid, state_o} !== {1'b1, S_CLEAR}) begin bad++; $display("FAIL pause_release: got v=%0b st=%0d want v=1 st=3", clr_valid, state_o); end
    pause = 1'b1; clr_ready = 1'b1;
    tick();
    m_score += PTS; m_dots--;
    total++;
    if ({clr_valid, score, dots_left} !== {1'b0, 16'(m_score), 8'(m_dots)}) begin
      bad++; $display("FAIL pause_hs: got v=%0b sc=%0d dl=%0d want v=0 sc=%0d dl=%0d", clr_valid, score, dots_left, m_score, m_dots);
    end
    pause = 1'b0; clr_ready = 1'b0; q_dot = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_clear_handshake();
    test_invalid_cells();
    test_random();
    test_level_done();
    test_saturation();
    test_reset_mid_clear();
`ifdef DOT_ROUND_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
